fft16_input_framer: RTL

//  Upstream stage of the 16-point FFT core. Accepts one complex Q-format sample
//  per cycle over a valid/ready stream and assembles frames of 16 samples in

---
 rtl/fft16_input_framer_pkg.sv | 20 ++
 rtl/fft16_input_framer_if.sv | 19 +
 rtl/fft16_input_framer_sample_bank.sv | 46 ++++
 rtl/fft16_input_framer.sv | 111 +++++++++++
 4 files changed

// File: rtl/fft16_input_framer_pkg.sv
// Package shared by the FFT16 input framer files.
//   FFT16_POINTS : frame length (fixed at 16)
//   FFT16_AW     : slot index width (4 bits)
//   bitrev4()    : 4-bit bit reversal used for bit-reversed slot ordering
//   `FFT16_SLOT(k, n) : part-select of slot k in a flat bus of n-bit words
//                       (same slot layout as the FFT16_top inputs)
`ifndef FFT16_SLOT
`define FFT16_SLOT(k, n) ((k) * (n)) +: (n)
`endif

package fft16_input_framer_pkg;

  localparam int FFT16_POINTS = 16;
  localparam int FFT16_AW     = 4;

  function automatic logic [FFT16_AW-1:0] bitrev4(input logic [FFT16_AW-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft16_input_framer_if.sv
// Sample stream interface into the FFT16 input framer.
//   valid : source has a sample this cycle
//   re/im : complex sample, N-bit two's complement each
//   ready : framer can accept a sample this cycle
// Handshake: a sample transfers on every rising clock edge where valid and
// ready are both high. The source holds valid/re/im until that edge; ready
// depends only on framer registers, never on valid.
// Modports: master = sample source, slave = framer.
interface fft16_input_framer_if #(
  parameter int N = 16
) ();
  logic         valid;
  logic [N-1:0] re;
  logic [N-1:0] im;
  logic         ready;

  modport master (output valid, output re, output im, input ready);
  modport slave  (input valid, input re, input im, output ready);
endinterface

// File: rtl/fft16_input_framer_sample_bank.sv
// One 16-entry complex sample bank for the FFT16 input framer.
// Single write port, full parallel read of all 16 slots.
//   clk, rst_n          : clock, asynchronous active-low reset (clears all slots)
//   we, addr            : write enable and slot index
//   wr_re, wr_im        : sample written to slot addr
//   rd_re_flat/rd_im_flat : all slots, slot k at [k*N +: N]
module fft16_input_framer_sample_bank
  import fft16_input_framer_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [FFT16_AW-1:0]       addr,
  input  logic [N-1:0]              wr_re,
  input  logic [N-1:0]              wr_im,
  output logic [FFT16_POINTS*N-1:0] rd_re_flat,
  output logic [FFT16_POINTS*N-1:0] rd_im_flat
);

  logic [N-1:0] mem_re [FFT16_POINTS];
  logic [N-1:0] mem_im [FFT16_POINTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FFT16_POINTS; k++) begin
        mem_re[k] <= '0;
        mem_im[k] <= '0;
      end
    end else if (we) begin
      mem_re[addr] <= wr_re;
      mem_im[addr] <= wr_im;
    end
  end

  always_comb begin
    rd_re_flat = '0;
    rd_im_flat = '0;
    for (int k = 0; k < FFT16_POINTS; k++) begin
      rd_re_flat[`FFT16_SLOT(k, N)] = mem_re[k];
      rd_im_flat[`FFT16_SLOT(k, N)] = mem_im[k];
    end
  end

endmodule

// File: rtl/fft16_input_framer.sv
// FFT16 input framer: collects 16 streamed complex samples into ping-pong
// banks and presents each full frame as 16 parallel words, held until the
// FFT pulses i_fft_done. Data passes through unmodified (Q8 fraction kept).
// Build option: define FFT16_IN_BITREV_EN to write arrival index k into slot
// bitrev4(k); otherwise slot k. Handshake and timing are identical.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   s_in                  : sample stream (valid/re/im/ready), slave side
//   i_flush               : discard the partially filled (or pending) frame
//   i_fft_done            : FFT finished with the presented frame (pulse)
//   o_start               : one-cycle pulse, a new frame is presented
//   o_busy                : a frame is presented and held for the FFT
//   o_fill_cnt            : samples in the filling bank (0..16)
//   o_re_flat, o_im_flat  : presented frame, slot k at [k*N +: N]
module fft16_input_framer
  import fft16_input_framer_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  fft16_input_framer_if.slave       s_in,
  input  logic                      i_flush,
  input  logic                      i_fft_done,
  output logic                      o_start,
  output logic                      o_busy,
  output logic [4:0]                o_fill_cnt,
  output logic [FFT16_POINTS*N-1:0] o_re_flat,
  output logic [FFT16_POINTS*N-1:0] o_im_flat
);

  logic [4:0]          fill_cnt;
  logic                wbank;
  logic                pbank;
  logic                full;
  logic                accept;
  logic                last_accept;
  logic                swap;
  logic                wr_en;
  logic [FFT16_AW-1:0] wr_addr;

  logic [FFT16_POINTS*N-1:0] b0_re, b0_im, b1_re, b1_im;

  assign full        = (fill_cnt == 5'd16);
  assign s_in.ready  = !full;
  assign accept      = s_in.valid && !full;
  assign last_accept = accept && (fill_cnt == 5'd15);
  // The 16th accept may swap on its own edge so an idle FFT sees o_start in
  // the very next cycle; a frame that completed earlier swaps when the FFT
  // frees up. Flush cancels the swap and discards the pending frame.
  assign swap  = !i_flush && (!o_busy || i_fft_done) && (full || last_accept);
  assign wr_en = accept && !i_flush;

`ifdef FFT16_IN_BITREV_EN
  assign wr_addr = bitrev4(fill_cnt[FFT16_AW-1:0]);
`else
  assign wr_addr = fill_cnt[FFT16_AW-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_cnt <= '0;
      wbank    <= 1'b0;
      pbank    <= 1'b0;
      o_busy   <= 1'b0;
      o_start  <= 1'b0;
    end else begin
      o_start <= swap;
      if (i_flush || swap) begin
        fill_cnt <= '0;
      end else if (accept) begin
        fill_cnt <= fill_cnt + 5'd1;
      end
      if (swap) begin
        pbank  <= wbank;
        wbank  <= !wbank;
        o_busy <= 1'b1;
      end else if (i_fft_done) begin
        o_busy <= 1'b0;
      end
    end
  end

  // While busy, wbank != pbank, so the presented bank is never written.
  fft16_input_framer_sample_bank #(.N(N)) u_bank0 (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .we         (wr_en && !wbank),
    .addr       (wr_addr),
    .wr_re      (s_in.re),
    .wr_im      (s_in.im),
    .rd_re_flat (b0_re),
    .rd_im_flat (b0_im)
  );

  fft16_input_framer_sample_bank #(.N(N)) u_bank1 (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .we         (wr_en && wbank),
    .addr       (wr_addr),
    .wr_re      (s_in.re),
    .wr_im      (s_in.im),
    .rd_re_flat (b1_re),
    .rd_im_flat (b1_im)
  );

  assign o_re_flat  = pbank ? b1_re : b0_re;
  assign o_im_flat  = pbank ? b1_im : b0_im;
  assign o_fill_cnt = fill_cnt;

endmodule
